// File: rtl/link_session.sv
// -----------------------------------------------------------------------------
// link_session
//
// Session controller for the two-player Snake byte link. It turns a local
// start request into a START/ACK exchange, answers a peer START with a
// start_game pulse, sends heartbeats while the game runs, and raises con_error
// when the peer stays silent for too long (ACK or heartbeat timeout).
//
// Link codes: START = 8'hA5, ACK = 8'h5A, HEARTBEAT = 8'h3C. Any other rx byte
// is not decoded but still counts as proof of life while running.
//
// game_mode encoding on 'mode' (3 bits):
//   0 MENU, 1 PLAY, 2 WIN, 3 LOSE, 4 DRAW, 5 ERROR
//
// Ports:
//   clk_75      in   system clock (75 MHz)
//   rst         in   synchronous active-high reset
//   local_start in   one-cycle pulse, local player started the game
//   mode        in   current game mode (encoding above)
//   rx_data     in   received byte
//   rx_valid    in   one-cycle pulse, rx_data valid
//   tx_ready    in   UART TX accepts a byte
//   tx_data     out  byte to send (registered)
//   tx_valid    out  tx_data valid, held until accepted (registered)
//   start_game  out  one-cycle pulse, peer started the game (registered)
//   con_error   out  link failure level (registered)
// -----------------------------------------------------------------------------
module link_session #(
    parameter int HB_PERIOD = 750000,
    parameter int TIMEOUT   = 7500000,
    parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic       clk_75,
    input  logic       rst,
    input  logic       local_start,
    input  logic [2:0] mode,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       start_game,
    output logic       con_error
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SEND_START = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK   = 3'd2;
    localparam logic [2:0] ST_SEND_ACK   = 3'd3;
    localparam logic [2:0] ST_RUN        = 3'd4;
    localparam logic [2:0] ST_ERROR      = 3'd5;

    localparam logic [2:0] MODE_MENU = 3'd0;
    localparam logic [2:0] MODE_WIN  = 3'd2;
    localparam logic [2:0] MODE_LOSE = 3'd3;
    localparam logic [2:0] MODE_DRAW = 3'd4;

    localparam logic [7:0] CODE_START = 8'hA5;
    localparam logic [7:0] CODE_ACK   = 8'h5A;
    localparam logic [7:0] CODE_HB    = 8'h3C;

    // Deferred RUN exit: where to go once a pending heartbeat has transferred.
    localparam logic [1:0] EXIT_NONE = 2'd0;
    localparam logic [1:0] EXIT_IDLE = 2'd1;
    localparam logic [1:0] EXIT_ERR  = 2'd2;

    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_PERIOD - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Saturating increment shared by both counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] hb_cnt_q, hb_cnt_d;
    logic [CNT_W-1:0] rx_tmr_q, rx_tmr_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             start_game_q, start_game_d;
    logic             con_error_q, con_error_d;
    logic [1:0]       exit_q, exit_d;

    logic rx_start_s;
    logic rx_ack_s;
    logic tx_fire_s;
    logic run_to_s;
    logic mode_end_s;
    logic [1:0] exit_sel_s;

    assign rx_start_s = rx_valid && (rx_data == CODE_START);
    assign rx_ack_s   = rx_valid && (rx_data == CODE_ACK);
    assign tx_fire_s  = tx_valid_q && tx_ready;
    assign mode_end_s = (mode == MODE_WIN) || (mode == MODE_LOSE) || (mode == MODE_DRAW);

    // RUN exit request: a fresh timeout beats mode-end, and an already latched
    // error is never downgraded to a plain return to IDLE.
    always_comb begin
        run_to_s   = 1'b0;
        exit_sel_s = exit_q;
        if (!rx_valid && (rx_tmr_q == TO_LAST)) begin
            run_to_s = 1'b1;
        end else begin
            run_to_s = 1'b0;
        end
        if (run_to_s || (exit_q == EXIT_ERR)) begin
            exit_sel_s = EXIT_ERR;
        end else if (mode_end_s || (exit_q == EXIT_IDLE)) begin
            exit_sel_s = EXIT_IDLE;
        end else begin
            exit_sel_s = EXIT_NONE;
        end
    end

    // Next-state logic for the session FSM, counters and output registers.
    always_comb begin
        state_d      = state_q;
        hb_cnt_d     = hb_cnt_q;
        rx_tmr_d     = rx_tmr_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        start_game_d = 1'b0;
        con_error_d  = con_error_q;
        exit_d       = exit_q;

        case (state_q)
            ST_IDLE: begin
                con_error_d = 1'b0;
                exit_d      = EXIT_NONE;
                // A peer START wins over a simultaneous local start.
                if (rx_start_s) begin
                    state_d      = ST_SEND_ACK;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = CODE_ACK;
                    start_game_d = 1'b1;
                end else if (local_start) begin
                    state_d    = ST_SEND_START;
                    tx_valid_d = 1'b1;
                    tx_data_d  = CODE_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND_START: begin
                if (tx_fire_s) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_WAIT_ACK;
                    rx_tmr_d   = CNT_ZERO;
                end else begin
                    state_d = ST_SEND_START;
                end
            end

            ST_WAIT_ACK: begin
                if (rx_ack_s) begin
                    state_d  = ST_RUN;
                    hb_cnt_d = CNT_ZERO;
                    rx_tmr_d = CNT_ZERO;
                end else if (rx_start_s) begin
                    // Crossed starts: the peer already started, just acknowledge.
                    state_d    = ST_SEND_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = CODE_ACK;
                end else if (rx_tmr_q == TO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    rx_tmr_d = sat_inc(rx_tmr_q);
                end
            end

            ST_SEND_ACK: begin
                if (tx_fire_s) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_RUN;
                    hb_cnt_d   = CNT_ZERO;
                    rx_tmr_d   = CNT_ZERO;
                end else begin
                    state_d = ST_SEND_ACK;
                end
            end

            ST_RUN: begin
                if (rx_valid) begin
                    rx_tmr_d = CNT_ZERO;
                end else if (run_to_s) begin
                    rx_tmr_d = rx_tmr_q;
                end else begin
                    rx_tmr_d = sat_inc(rx_tmr_q);
                end

                if (tx_valid_q) begin
                    // A heartbeat in flight must finish before any exit.
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        hb_cnt_d   = CNT_ZERO;
                        exit_d     = EXIT_NONE;
                        if (exit_sel_s == EXIT_ERR) begin
                            state_d = ST_ERROR;
                        end else if (exit_sel_s == EXIT_IDLE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        exit_d = exit_sel_s;
                    end
                end else if (exit_sel_s == EXIT_ERR) begin
                    state_d = ST_ERROR;
                    exit_d  = EXIT_NONE;
                end else if (exit_sel_s == EXIT_IDLE) begin
                    state_d = ST_IDLE;
                    exit_d  = EXIT_NONE;
                end else if (hb_cnt_q == HB_LAST) begin
                    // Counter holds at the last value until the byte transfers.
                    tx_valid_d = 1'b1;
                    tx_data_d  = CODE_HB;
                end else begin
                    hb_cnt_d = sat_inc(hb_cnt_q);
                end
            end

            ST_ERROR: begin
                // Leave only after con_error has been visible for a cycle.
                if (con_error_q && (mode == MODE_MENU)) begin
                    state_d     = ST_IDLE;
                    con_error_d = 1'b0;
                    hb_cnt_d    = CNT_ZERO;
                    rx_tmr_d    = CNT_ZERO;
                end else begin
                    con_error_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tx_valid_d  = 1'b0;
                con_error_d = 1'b0;
                exit_d      = EXIT_NONE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_75) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hb_cnt_q     <= CNT_ZERO;
            rx_tmr_q     <= CNT_ZERO;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            start_game_q <= 1'b0;
            con_error_q  <= 1'b0;
            exit_q       <= EXIT_NONE;
        end else begin
            state_q      <= state_d;
            hb_cnt_q     <= hb_cnt_d;
            rx_tmr_q     <= rx_tmr_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            start_game_q <= start_game_d;
            con_error_q  <= con_error_d;
            exit_q       <= exit_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign start_game = start_game_q;
    assign con_error  = con_error_q;

endmodule

// File: tb/tb_link_session.sv
// -----------------------------------------------------------------------------
// tb_link_session
//
// Scoreboard bench for link_session with HB_PERIOD=8, TIMEOUT=32. Stimulus
// pushes expected output events (tx transfer, start_game pulse, con_error edge)
// with their expected cycle; a negedge monitor pops and compares each event
// the DUT produces. Direct checks cover reset values and held tx outputs.
// -----------------------------------------------------------------------------
module tb_link_session;

    localparam int HB = 8;
    localparam int TO = 32;

    localparam logic [2:0] MODE_MENU  = 3'd0;
    localparam logic [2:0] MODE_PLAY  = 3'd1;
    localparam logic [2:0] MODE_WIN   = 3'd2;
    localparam logic [2:0] MODE_LOSE  = 3'd3;
    localparam logic [2:0] MODE_DRAW  = 3'd4;
    localparam logic [2:0] MODE_ERROR = 3'd5;

    localparam int EV_TX  = 0;
    localparam int EV_SG  = 1;
    localparam int EV_ERR = 2;

    logic       clk_75 = 1'b0;
    logic       rst;
    logic       local_start;
    logic [2:0] mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       start_game;
    logic       con_error;

    always #5 clk_75 = ~clk_75;

    link_session #(.HB_PERIOD(HB), .TIMEOUT(TO)) dut (
        .clk_75      (clk_75),
        .rst         (rst),
        .local_start (local_start),
        .mode        (mode),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .start_game  (start_game),
        .con_error   (con_error)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic err_prev = 1'b0;

    // Cycle counter used to timestamp events.
    always @(posedge clk_75) cyc <= cyc + 1;

    task automatic expect_ev(input int kind, input logic [7:0] data, input int at);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [7:0] data);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind %0d data %h at cycle %0d, expected no event", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %h at cycle %0d, expected kind %0d data %h at cycle %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_75);
        #1;
    endtask

    // Monitor: every DUT output event is checked against the scoreboard.
    always @(negedge clk_75) begin
        if (mon_en) begin
            if (start_game) got(EV_SG, 8'h01);
            if (tx_valid && tx_ready) got(EV_TX, tx_data);
            if (con_error !== err_prev) begin
                got(EV_ERR, {7'b0000000, con_error});
                err_prev <= con_error;
            end
        end
    end

    // Peer-initiated start, optionally together with a local start, ended by end_mode.
    task automatic remote_start(input logic with_local, input logic [2:0] end_mode);
        int e;
        e = cyc;
        rx_valid    = 1'b1;
        rx_data     = 8'hA5;
        local_start = with_local;
        expect_ev(EV_SG, 8'h01, e + 1);
        expect_ev(EV_TX, 8'h5A, e + 1);
        expect_ev(EV_TX, 8'h3C, e + 10);
        tick();
        rx_valid    = 1'b0;
        local_start = 1'b0;
        repeat (10) tick();
        mode = end_mode;
        repeat (20) tick();
        mode = MODE_MENU;
        tick();
    endtask

    initial begin
        int c;
        int d;
        int t;
        int m;

        rst         = 1'b1;
        local_start = 1'b0;
        mode        = MODE_MENU;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        tx_ready    = 1'b1;

        // Reset values.
        repeat (3) tick();
        chk("reset tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset start_game", {7'b0, start_game}, 8'h00);
        chk("reset con_error", {7'b0, con_error}, 8'h00);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // Local start, heartbeats with live peer, game end with pending heartbeat.
        c = cyc;
        local_start = 1'b1;
        expect_ev(EV_TX, 8'hA5, c + 1);
        tick();
        local_start = 1'b0;
        repeat (4) tick();
        d = cyc;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        for (int k = 0; k < 4; k++) expect_ev(EV_TX, 8'h3C, d + 9 + 9 * k);
        expect_ev(EV_TX, 8'h3C, d + 56);
        for (int r = 1; r <= 57; r++) begin
            tick();
            rx_valid = ((r % 10) == 0) && (r <= 40);
            rx_data  = 8'h3C;
            if (r == 42) tx_ready = 1'b0;
            if (r == 48) mode = MODE_WIN;
            if (r >= 45 && r <= 55) begin
                chk("hb held valid", {7'b0, tx_valid}, 8'h01);
                chk("hb held data", tx_data, 8'h3C);
            end
            if (r == 56) tx_ready = 1'b1;
            if (r == 57) mode = MODE_MENU;
        end
        repeat (25) tick();
        chk("no error after run", {7'b0, con_error}, 8'h00);

        // Remote start, alone and together with local_start.
        remote_start(1'b0, MODE_LOSE);
        remote_start(1'b1, MODE_DRAW);

        // ACK timeout, error held by mode=ERROR, cleared by MENU.
        c = cyc;
        local_start = 1'b1;
        mode = MODE_PLAY;
        expect_ev(EV_TX, 8'hA5, c + 1);
        expect_ev(EV_ERR, 8'h01, c + 35);
        tick();
        local_start = 1'b0;
        repeat (35) tick();
        mode = MODE_ERROR;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("error held", {7'b0, con_error}, 8'h01);
            rx_valid = (i == 3);
            rx_data  = 8'hA5;
        end
        m = cyc;
        mode = MODE_MENU;
        expect_ev(EV_ERR, 8'h00, m + 1);
        repeat (3) tick();

        // TX backpressure on START, then heartbeat loss in RUN.
        c = cyc;
        tx_ready = 1'b0;
        local_start = 1'b1;
        mode = MODE_PLAY;
        expect_ev(EV_TX, 8'hA5, c + 21);
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 1) local_start = 1'b0;
            if (i <= 20) begin
                chk("start held valid", {7'b0, tx_valid}, 8'h01);
                chk("start held data", tx_data, 8'hA5);
            end
            if (i == 21) tx_ready = 1'b1;
        end
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        t = cyc + 1;
        for (int k = 0; k < 7; k++) expect_ev(EV_TX, 8'h3C, t + 8 + 9 * k);
        expect_ev(EV_ERR, 8'h01, t + 65);
        expect_ev(EV_ERR, 8'h00, t + 67);
        for (int r = 0; r <= 66; r++) begin
            tick();
            rx_valid = (r == 31);
            rx_data  = 8'h11;
            if (r == 66) mode = MODE_MENU;
        end
        repeat (3) tick();

        // Crossed starts: peer START while waiting for ACK.
        c = cyc;
        local_start = 1'b1;
        mode = MODE_PLAY;
        expect_ev(EV_TX, 8'hA5, c + 1);
        tick();
        local_start = 1'b0;
        repeat (3) tick();
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        expect_ev(EV_TX, 8'h5A, c + 5);
        expect_ev(EV_TX, 8'h3C, c + 14);
        tick();
        rx_valid = 1'b0;
        repeat (10) tick();
        mode = MODE_WIN;
        repeat (20) tick();
        mode = MODE_MENU;

        // Reset in the middle of a stalled START drops tx_valid.
        tx_ready = 1'b0;
        local_start = 1'b1;
        tick();
        local_start = 1'b0;
        chk("stalled start valid", {7'b0, tx_valid}, 8'h01);
        tick();
        rst = 1'b1;
        tick();
        chk("rst drops tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst clears tx_data", tx_data, 8'h00);
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (10) tick();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending events: got %0d unmatched expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
